// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Brief    : Debounced 4-switch front end driving a 4-LED mode/pattern FSM.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int TICK_SLOW      = 12500000,
   parameter int TICK_FAST      = 3125000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Switch_1,
   input  logic       i_Switch_2,
   input  logic       i_Switch_3,
   input  logic       i_Switch_4,
   output logic       o_LED_1,
   output logic       o_LED_2,
   output logic       o_LED_3,
   output logic       o_LED_4,
   output logic [1:0] o_Mode
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CHASE = 2'b01,
      S_BLINK = 2'b10,
      S_COUNT = 2'b11
   } state_t;

   localparam int c_db_w     = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int c_tick_max = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
   localparam int c_tick_w   = $clog2(c_tick_max);

   localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_LIMIT - 1);
   localparam logic [c_tick_w-1:0] c_slow_last = c_tick_w'(TICK_SLOW - 1);
   localparam logic [c_tick_w-1:0] c_fast_last = c_tick_w'(TICK_FAST - 1);

   logic [3:0]          w_sw_raw;
   logic [3:0]          r_sync1;
   logic [3:0]          r_sync2;
   logic [3:0]          w_stable;
   logic [3:0]          r_stable_q;
   logic [3:0]          w_press;
   logic                w_any_press;

   state_t              r_mode;
   logic [3:0]          r_pattern;
   logic                r_speed;
   logic                r_pause;
   logic [c_tick_w-1:0] r_tick_cnt;
   logic [c_tick_w-1:0] w_tick_last;
   logic                w_active;
   logic                w_tick;

   assign w_sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_stable_q <= '0;
      end else begin
         r_sync1    <= w_sw_raw;
         r_sync2    <= r_sync1;
         r_stable_q <= w_stable;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
         logic [c_db_w-1:0] r_db_cnt;
         logic              r_stable;

         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               r_db_cnt <= '0;
               r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
               r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
               r_db_cnt <= '0;
               r_stable <= ~r_stable;
            end else begin
               r_db_cnt <= r_db_cnt + c_db_w'(1);
            end
         end

         assign w_stable[gi] = r_stable;
      end
   endgenerate

   // Only rising edges of the debounced level are events; releases are silent.
   assign w_press     = w_stable & ~r_stable_q;
   assign w_any_press = |w_press;

   assign w_tick_last = r_speed ? c_fast_last : c_slow_last;
   assign w_active    = (r_mode != S_IDLE) && !r_pause;
   // A press restarts the step interval, so it also swallows a coincident tick.
   assign w_tick      = w_active && !w_any_press && (r_tick_cnt == w_tick_last);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_tick_cnt <= '0;
      end else if (w_any_press) begin
         r_tick_cnt <= '0;
      end else if (w_active) begin
         if (r_tick_cnt == w_tick_last) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
         end
      end
   end

   function automatic logic [3:0] f_step(input state_t mode, input logic [3:0] pat);
      logic [3:0] nxt;
      nxt = 4'b0000;
      case (mode)
         S_CHASE: nxt = {pat[2:0], pat[3]};
         S_BLINK: nxt = ~pat;
         S_COUNT: nxt = pat + 4'd1;
         default: nxt = 4'b0000;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_mode    <= S_IDLE;
         r_pattern <= 4'b0000;
         r_speed   <= 1'b0;
         r_pause   <= 1'b0;
      end else if (w_press[3]) begin
         r_mode    <= S_IDLE;
         r_pattern <= 4'b0000;
         r_speed   <= 1'b0;
         r_pause   <= 1'b0;
      end else if (w_press[0]) begin
         r_pause <= 1'b0;
         if (w_press[1]) begin
            r_speed <= ~r_speed;
         end
         case (r_mode)
            S_IDLE: begin
               r_mode    <= S_CHASE;
               r_pattern <= 4'b0001;
            end
            S_CHASE: begin
               r_mode    <= S_BLINK;
               r_pattern <= 4'b1111;
            end
            S_BLINK: begin
               r_mode    <= S_COUNT;
               r_pattern <= 4'b0000;
            end
            default: begin
               r_mode    <= S_IDLE;
               r_pattern <= 4'b0000;
            end
         endcase
      end else begin
         if (w_press[2] && (r_mode != S_IDLE)) begin
            r_pause <= ~r_pause;
         end
         if (w_press[1]) begin
            r_speed <= ~r_speed;
         end
         if (w_tick) begin
            r_pattern <= f_step(r_mode, r_pattern);
         end
      end
   end

   assign o_LED_1 = r_pattern[0];
   assign o_LED_2 = r_pattern[1];
   assign o_LED_3 = r_pattern[2];
   assign o_LED_4 = r_pattern[3];
   assign o_Mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Brief    : Directed self-checking bench for led_pattern_ctrl (small limits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       sw1, sw2, sw3, sw4;
   logic       led1, led2, led3, led4;
   logic [1:0] mode;
   logic [3:0] leds;

   int n_checks;
   int n_errors;

   led_pattern_ctrl #(
      .DEBOUNCE_LIMIT (4),
      .TICK_SLOW      (8),
      .TICK_FAST      (2)
   ) dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_Switch_1 (sw1),
      .i_Switch_2 (sw2),
      .i_Switch_3 (sw3),
      .i_Switch_4 (sw4),
      .o_LED_1    (led1),
      .o_LED_2    (led2),
      .o_LED_3    (led3),
      .o_LED_4    (led4),
      .o_Mode     (mode)
   );

   assign leds = {led4, led3, led2, led1};

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Advance n rising edges, landing 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [1:0] exp_mode, input logic [3:0] exp_led);
      n_checks++;
      assert ({mode, leds} === {exp_mode, exp_led}) else begin
         n_errors++;
         $error("FAIL %s: observed mode=%b leds=%b, expected mode=%b leds=%b",
                tag, mode, leds, exp_mode, exp_led);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clk_en   = 1'b0;
      rst_n    = 1'b1;
      {sw1, sw2, sw3, sw4} = 4'b0000;

      // Reset with the clock stopped.
      #1 rst_n = 1'b0;
      #2 check("reset_noclk", 2'b00, 4'b0000);
      clk_en = 1'b1;
      #9 rst_n = 1'b1;
      cyc(20);
      check("idle_20", 2'b00, 4'b0000);

      // Short glitch on Sw1 must not register.
      sw1 = 1'b1; cyc(3); sw1 = 1'b0; cyc(10);
      check("sw1_glitch", 2'b00, 4'b0000);

      // Held Sw1: event lands on edge 7.
      sw1 = 1'b1; cyc(6);
      check("sw1_edge6", 2'b00, 4'b0000);
      cyc(1);
      check("sw1_edge7", 2'b01, 4'b0001);

      // CHASE slow stepping.
      cyc(7); check("chase_pre", 2'b01, 4'b0001);
      cyc(1); check("chase_1", 2'b01, 4'b0010);
      cyc(8); check("chase_2", 2'b01, 4'b0100);
      cyc(8); check("chase_3", 2'b01, 4'b1000);
      cyc(8); check("chase_4", 2'b01, 4'b0001);
      cyc(18); check("sw1_held50", 2'b01, 4'b0100);
      sw1 = 1'b0; cyc(7);

      // Into BLINK.
      sw1 = 1'b1; cyc(7);
      check("blink_entry", 2'b10, 4'b1111);
      sw1 = 1'b0; cyc(7);
      check("blink_pre", 2'b10, 4'b1111);

      // Pause in BLINK.
      sw3 = 1'b1; cyc(7);
      check("blink_pause", 2'b10, 4'b0000);
      sw3 = 1'b0; cyc(50);
      check("blink_frozen", 2'b10, 4'b0000);
      sw3 = 1'b1; cyc(7);
      check("blink_resume", 2'b10, 4'b0000);
      sw3 = 1'b0; cyc(7);
      check("blink_resume7", 2'b10, 4'b0000);
      cyc(1);
      check("blink_resume8", 2'b10, 4'b1111);

      // Into COUNT, then fast speed.
      sw1 = 1'b1; cyc(7);
      check("count_entry", 2'b11, 4'b0000);
      sw1 = 1'b0; cyc(7);
      sw2 = 1'b1; cyc(7);
      check("count_fast", 2'b11, 4'b0001);
      sw2 = 1'b0;
      cyc(1);  check("fast_1", 2'b11, 4'b0001);
      cyc(1);  check("fast_2", 2'b11, 4'b0010);
      cyc(26); check("fast_f", 2'b11, 4'b1111);
      cyc(1);  check("fast_f_hold", 2'b11, 4'b1111);
      cyc(1);  check("fast_wrap", 2'b11, 4'b0000);

      // Back to slow.
      sw2 = 1'b1; cyc(7);
      check("slow_again", 2'b11, 4'b0011);
      sw2 = 1'b0; cyc(7);
      check("slow_pre", 2'b11, 4'b0011);
      cyc(1);
      check("slow_step", 2'b11, 4'b0100);

      // COUNT -> IDLE -> CHASE with a same-cycle speed toggle.
      sw1 = 1'b1; cyc(7);
      check("count_to_idle", 2'b00, 4'b0000);
      sw1 = 1'b0; cyc(7);
      sw1 = 1'b1; sw2 = 1'b1; cyc(7);
      check("chase_sw1sw2", 2'b01, 4'b0001);
      sw1 = 1'b0; sw2 = 1'b0; cyc(7);
      check("chase_fast", 2'b01, 4'b1000);
      sw3 = 1'b1; cyc(7);
      check("chase_pause", 2'b01, 4'b0100);
      sw3 = 1'b0; cyc(7);
      check("chase_paused", 2'b01, 4'b0100);

      // Sw4 wins over Sw1, and clears speed.
      sw4 = 1'b1; sw1 = 1'b1; cyc(7);
      check("sw4_sw1", 2'b00, 4'b0000);
      sw4 = 1'b0; sw1 = 1'b0; cyc(7);
      sw1 = 1'b1; cyc(7);
      check("chase_after_sw4", 2'b01, 4'b0001);
      sw1 = 1'b0; cyc(7);
      check("slow_after_sw4", 2'b01, 4'b0001);
      cyc(1);
      check("slow_step_sw4", 2'b01, 4'b0010);

      // Asynchronous reset between edges.
      #2 rst_n = 1'b0;
      #1 check("async_reset", 2'b00, 4'b0000);
      #3 rst_n = 1'b1;
      cyc(3);
      check("post_reset", 2'b00, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
